cbc_dec_chain: RTL and testbench

- CBC decryption chaining controller: the inverse-direction counterpart of the encrypt-side pre-XOR stage.
- Accepts ciphertext blocks and issues each to the block-cipher decrypt core.
- XORs each core result with the IV (first block) or the previous ciphertext (later blocks) to produce plaintext.
- Sits between the ciphertext source and the plaintext sink, wrapping the decrypt core. One block in flight at a time.

---
 rtl/cbc_dec_chain_if.sv | 35 +++
 rtl/cbc_dec_chain.sv | 106 ++++++++++
 tb/tb_cbc_dec_chain.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cbc_dec_chain_if.sv
// CBC decrypt chaining controller bus bundle.
// Ciphertext in, decrypt-core link, plaintext out.
interface cbc_dec_chain_if #(
  parameter int BLK_W = 128,
  parameter int CNT_W = 32
);
  logic             iv_load;
  logic [0:BLK_W-1] iv;
  logic             ct_valid;
  logic             ct_ready;
  logic [0:BLK_W-1] ct;
  logic             dec_start;
  logic [0:BLK_W-1] dec_ct;
  logic             dec_done;
  logic [0:BLK_W-1] dec_pt;
  logic             pt_valid;
  logic             pt_ready;
  logic [0:BLK_W-1] pt;
  logic [CNT_W-1:0] blk_cnt;
  logic             busy;

  modport slave (
    input  iv_load, iv, ct_valid, ct,
    input  dec_done, dec_pt, pt_ready,
    output ct_ready, dec_start, dec_ct,
    output pt_valid, pt, blk_cnt, busy
  );

  modport master (
    output iv_load, iv, ct_valid, ct,
    output dec_done, dec_pt, pt_ready,
    input  ct_ready, dec_start, dec_ct,
    input  pt_valid, pt, blk_cnt, busy
  );
endinterface

// File: rtl/cbc_dec_chain.sv
// CBC decrypt chaining controller.
// One block in flight: issue to core, XOR result with chain.
module cbc_dec_chain #(
  parameter int BLK_W = 128,
  parameter int CNT_W = 32
) (
  input logic           clk,
  input logic           rst_n,
  cbc_dec_chain_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    DEC,
    HOLD
  } state_t;

  state_t state_q, state_d;

  logic [0:BLK_W-1] chain_q;
  logic [0:BLK_W-1] dec_ct_q;
  logic [0:BLK_W-1] pt_q;
  logic [CNT_W-1:0] cnt_q;
  logic             iv_ok_q;
  logic             start_q;
  logic             pt_valid_q;

  logic ct_ready_c;
  logic accept;
  logic done_ok;
  logic pt_hs;
  logic iv_take;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake decode.
  always_comb begin
    state_d    = state_q;
    ct_ready_c = 1'b0;
    accept     = 1'b0;
    done_ok    = 1'b0;
    pt_hs      = 1'b0;
    iv_take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        iv_take    = bus.iv_load;
        ct_ready_c = iv_ok_q & ~bus.iv_load;
        accept     = bus.ct_valid & ct_ready_c;
        if (accept) state_d = DEC;
      end
      DEC: begin
        // The start cycle can't carry a result.
        done_ok = bus.dec_done & ~start_q;
        if (done_ok) state_d = HOLD;
      end
      HOLD: begin
        pt_hs = pt_valid_q & bus.pt_ready;
        if (pt_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: dec_ct doubles as the in-flight ciphertext.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q    <= '0;
      dec_ct_q   <= '0;
      pt_q       <= '0;
      cnt_q      <= '0;
      iv_ok_q    <= 1'b0;
      start_q    <= 1'b0;
      pt_valid_q <= 1'b0;
    end else begin
      start_q <= accept;
      if (iv_take) begin
        chain_q <= bus.iv;
        cnt_q   <= '0;
        iv_ok_q <= 1'b1;
      end
      if (accept) dec_ct_q <= bus.ct;
      if (done_ok) begin
        pt_q       <= bus.dec_pt ^ chain_q;
        chain_q    <= dec_ct_q;
        cnt_q      <= cnt_q + ONE;
        pt_valid_q <= 1'b1;
      end
      if (pt_hs) pt_valid_q <= 1'b0;
    end
  end

  assign bus.ct_ready  = ct_ready_c;
  assign bus.dec_start = start_q;
  assign bus.dec_ct    = dec_ct_q;
  assign bus.pt_valid  = pt_valid_q;
  assign bus.pt        = pt_q;
  assign bus.blk_cnt   = cnt_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cbc_dec_chain.sv
// Directed bench for cbc_dec_chain.
// Stub core answers dec_start after a fixed latency of 3.
module tb_cbc_dec_chain;

  typedef logic [0:127] blk_t;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;
  int   stub_cnt;
  blk_t stub_pt;

  cbc_dec_chain_if bus ();

  cbc_dec_chain dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub decrypt core: dec_done three cycles after dec_start.
  initial stub_cnt = 0;
  always @(posedge clk) begin
    bus.dec_done <= 1'b0;
    if (stub_cnt == 2) begin
      bus.dec_done <= 1'b1;
      bus.dec_pt   <= stub_pt;
    end
    if (bus.dec_start) stub_cnt <= 3;
    else if (stub_cnt > 0) stub_cnt <= stub_cnt - 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, need finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_iv(input blk_t v);
    bus.iv      = v;
    bus.iv_load = 1'b1;
    step();
    bus.iv_load = 1'b0;
  endtask

  task automatic run_to_pt(input blk_t c, input blk_t dp,
                           input blk_t ep, input logic [31:0] ec,
                           input string nm);
    int n;
    stub_pt      = dp;
    bus.ct       = c;
    bus.ct_valid = 1'b1;
    #1;
    n = 0;
    while (!bus.ct_ready && n < 10) begin
      step();
      n++;
    end
    total++;
    if (bus.ct_ready !== 1'b1) begin
      $display("FAIL %s accept: ct_ready=%b need 1", nm, bus.ct_ready);
      bus.ct_valid = 1'b0;
      return;
    end
    passed++;
    step();
    bus.ct_valid = 1'b0;
    total++;
    if (bus.dec_start !== 1'b1 || bus.dec_ct !== c)
      $display("FAIL %s start: dec_start=%b dec_ct=%h need 1 %h",
               nm, bus.dec_start, bus.dec_ct, c);
    else passed++;
    n = 0;
    while (!bus.pt_valid && n < 20) begin
      step();
      n++;
    end
    total++;
    if (n !== 4)
      $display("FAIL %s latency: got %0d need 4", nm, n);
    else passed++;
    total++;
    if (bus.pt !== ep)
      $display("FAIL %s pt: got %h need %h", nm, bus.pt, ep);
    else passed++;
    total++;
    if (bus.blk_cnt !== ec)
      $display("FAIL %s blk_cnt: got %h need %h", nm, bus.blk_cnt, ec);
    else passed++;
  endtask

  task automatic drain(input string nm);
    bus.pt_ready = 1'b1;
    step();
    bus.pt_ready = 1'b0;
    total++;
    if (bus.pt_valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL %s drain: pt_valid=%b busy=%b need 0 0",
               nm, bus.pt_valid, bus.busy);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.iv_load  = 1'b0;
    bus.iv       = '0;
    bus.ct_valid = 1'b0;
    bus.ct       = '0;
    bus.pt_ready = 1'b0;
    stub_pt      = '0;
    repeat (3) step();
    total++;
    if ({bus.ct_ready, bus.dec_start, bus.pt_valid, bus.busy} !== 4'b0)
      $display("FAIL reset ctl: got %b need 0000",
               {bus.ct_ready, bus.dec_start, bus.pt_valid, bus.busy});
    else passed++;
    total++;
    if (bus.pt !== '0 || bus.dec_ct !== '0 || bus.blk_cnt !== '0)
      $display("FAIL reset data: pt=%h dec_ct=%h cnt=%h need 0",
               bus.pt, bus.dec_ct, bus.blk_cnt);
    else passed++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_no_iv();
    int bad;
    bad          = 0;
    bus.ct       = {16{8'h77}};
    bus.ct_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.ct_ready || bus.dec_start || bus.busy) bad++;
      step();
    end
    bus.ct_valid = 1'b0;
    total++;
    if (bad !== 0)
      $display("FAIL no_iv accept: got %0d bad cycles need 0", bad);
    else passed++;
    total++;
    if (bus.blk_cnt !== 32'd0)
      $display("FAIL no_iv cnt: got %h need 0", bus.blk_cnt);
    else passed++;
  endtask

  task automatic test_chain();
    blk_t ep1;
    ep1 = 128'h1110_1312_1514_1716_1918_1B1A_1D1C_1F1E;
    load_iv(128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F);
    run_to_pt({16{8'hAA}}, {16{8'h11}}, ep1, 32'd1, "blk1");
    drain("blk1");
    run_to_pt({16{8'h55}}, {16{8'h11}}, {16{8'hBB}}, 32'd2, "blk2");
    drain("blk2");
  endtask

  task automatic test_hold_stall();
    int   bad;
    blk_t held;
    run_to_pt({16{8'h33}}, '0, {16{8'h55}}, 32'd3, "hold");
    held    = bus.pt;
    bad     = 0;
    bus.iv  = {16{8'hFF}};
    bus.ct  = {16{8'h99}};
    for (int i = 0; i < 10; i++) begin
      bus.iv_load  = i[0];
      bus.ct_valid = ~i[0];
      #1;
      if (bus.ct_ready || !bus.pt_valid || bus.pt !== held) bad++;
      if (dut.chain_q !== {16{8'h33}}) bad++;
      step();
    end
    bus.iv_load  = 1'b0;
    bus.ct_valid = 1'b0;
    total++;
    if (bad !== 0)
      $display("FAIL hold stall: got %0d bad cycles need 0", bad);
    else passed++;
    drain("hold");
    total++;
    if (dut.chain_q !== {16{8'h33}} || bus.blk_cnt !== 32'd3)
      $display("FAIL hold chain: chain=%h cnt=%h need 33.. 3",
               dut.chain_q, bus.blk_cnt);
    else passed++;
  endtask

  task automatic test_iv_priority();
    bus.iv       = {16{8'hFF}};
    bus.iv_load  = 1'b1;
    bus.ct       = {16{8'hCC}};
    bus.ct_valid = 1'b1;
    #1;
    total++;
    if (bus.ct_ready !== 1'b0)
      $display("FAIL prio ready: got %b need 0", bus.ct_ready);
    else passed++;
    step();
    bus.iv_load  = 1'b0;
    bus.ct_valid = 1'b0;
    total++;
    if (bus.busy !== 1'b0 || bus.blk_cnt !== 32'd0)
      $display("FAIL prio load: busy=%b cnt=%h need 0 0",
               bus.busy, bus.blk_cnt);
    else passed++;
    run_to_pt({16{8'hCC}}, {16{8'h11}}, {16{8'hEE}}, 32'd1, "prio");
    drain("prio");
  endtask

  task automatic test_reset_in_dec();
    int bad;
    stub_pt      = {16{8'h5A}};
    bus.ct       = {16{8'h12}};
    bus.ct_valid = 1'b1;
    #1;
    step();
    bus.ct_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.ct_ready, bus.dec_start, bus.pt_valid, bus.busy} !== 4'b0 ||
        bus.pt !== '0 || bus.dec_ct !== '0 || bus.blk_cnt !== '0)
      $display("FAIL rst_dec outs: ctl=%b pt=%h dct=%h cnt=%h need 0",
               {bus.ct_ready, bus.dec_start, bus.pt_valid, bus.busy},
               bus.pt, bus.dec_ct, bus.blk_cnt);
    else passed++;
    step();
    rst_n = 1'b1;
    total++;
    if (dut.iv_ok_q !== 1'b0)
      $display("FAIL rst_dec iv_ok: got %b need 0", dut.iv_ok_q);
    else passed++;
    bad          = 0;
    bus.ct_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (bus.pt_valid || bus.busy || bus.ct_ready) bad++;
      step();
    end
    bus.ct_valid = 1'b0;
    total++;
    if (bad !== 0)
      $display("FAIL rst_dec late_done: got %0d bad cycles need 0", bad);
    else passed++;
  endtask

  task automatic test_wrap();
    blk_t dp;
    dp = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    load_iv('0);
    force dut.cnt_q = 32'hFFFF_FFFF;
    step();
    release dut.cnt_q;
    #1;
    total++;
    if (bus.blk_cnt !== 32'hFFFF_FFFF)
      $display("FAIL wrap preload: got %h need ffffffff", bus.blk_cnt);
    else passed++;
    run_to_pt({16{8'h0F}}, dp, dp, 32'd0, "wrap");
    drain("wrap");
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_no_iv();
    test_chain();
    test_hold_stall();
    test_iv_priority();
    test_reset_in_dec();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
